button_panel_ctl: RTL and testbench
===================================

// Module: button_panel_ctl
// PURPOSE
//  Parametrised mouse-driven button panel controller; successor to the fixed three-button deal/hit/stand click logic.
//  Supports N vertically stacked buttons, per-button enable, and hover/pressed status for highlighting.
//  Issues a click only on press-and-release within the same enabled button, followed by a hold-off window.
//  Sits between hold_mouse (coords/buttons) and blackjack_FSM (one-cycle action pulses); hover/pressed feed draw_buttons.
// PARAMETERS
//  N_BTN        3     number of buttons (1..8)
//  X0           800   left edge of all buttons, pixels
//  Y0           100   top edge of button 0, pixels
//  BTN_W        120   button width, pixels
//  BTN_H        40    button height, pixels
//  Y_STEP       60    vertical pitch between button tops; must be >= BTN_H
//  SYNC_STAGES  2     synchroniser flops on left_mouse (>=2)
//  HOLDOFF      1000  cycles after a click during which new presses are ignored (>=1)
// PORTS
//  clk          in   1      system clock (same domain as vga_timing)
//  rst          in   1      synchronous reset, active-low
//  mouse_x      in   12     cursor x, pixels
//  mouse_y      in   12     cursor y, pixels
//  left_mouse   in   1      left button level, asynchronous to clk
//  enable       in   N_BTN  per-button enable; bit i = button i
//  hover        out  N_BTN  registered: cursor over enabled button i
//  pressed      out  N_BTN  one-hot: button i armed and cursor still over it
//  click        out  N_BTN  one-hot, one-cycle pulse: button i clicked
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state IDLE, sync flops, hit_q, counter = 0; hover/pressed/click = 0 next cycle.
//  Sync: left_mouse -> SYNC_STAGES flops -> left_s; left_p = left_s delayed 1; rise = left_s&~left_p; fall = ~left_s&left_p.
//  Hit test: inside_i = (X0<=x<X0+BTN_W) && (Y0+i*Y_STEP<=y<Y0+i*Y_STEP+BTN_H);
//   arithmetic in 13 bits unsigned, no wrap; registered into hit_q each cycle (1-cycle latency).
//  hover = hit_q & enable, registered. Overlap impossible (Y_STEP>=BTN_H); otherwise lowest index wins.
//  FSM states: IDLE, ARMED(idx), WAIT_REL, HOLD.
//   IDLE: rise with (hit_q&enable)!=0 -> ARMED, idx = lowest set bit; rise elsewhere -> WAIT_REL.
//   ARMED: enable[idx]==0 -> WAIT_REL (cancel; fall in that same cycle gives no click);
//          fall && hit_q[idx] -> click[idx]=1 next cycle, counter=HOLDOFF-1, -> HOLD;
//          fall && !hit_q[idx] -> IDLE, no click.
//   WAIT_REL: left_s==0 -> IDLE. Never clicks.
//   HOLD: counter decrements each cycle; at 0 -> IDLE if left_s==0, else -> WAIT_REL. Rises ignored.
//  pressed[idx] = 1 only in ARMED while hit_q[idx]; dragging off clears it, dragging back restores it.
//  Latency: click rises at the clk edge SYNC_STAGES after the edge that first samples left_mouse low.
//  click is exactly one cycle; at most one bit of click/pressed set at any time.
//  Cursor moving between buttons in IDLE only changes hover; no click without a press.
//  Reset mid-ARMED/HOLD: state lost, no click on the later release; a held button after reset gives no rise -> no click.
// TESTING
//  1 defaults, cursor (850,170), enable=3'b111, press 10 cycles, release -> click=3'b010 for 1 cycle at
//    edge SYNC_STAGES after the release sample; pressed=3'b010 while held; hover=3'b010.
//  2 press at (850,170), drag to (850,230) mid-hold, release -> click stays 0; pressed 3'b010->3'b000.
//  3 press at (100,100), drag to (850,110), release -> no click; hover=3'b001 after move.
//  4 boundary: x=919,y=139 -> hover[0]=1; x=920 or y=140 -> hover=0; y=159 -> 0, y=160 -> hover[1]=1.
//  5 HOLDOFF=20: click btn0, re-press 5 cycles after click -> ignored (no click, stays WAIT_REL until release);
//    re-press 30 cycles after click -> click=3'b001.
//  6 press btn1, drop enable[1] while held -> pressed=0, hover[1]=0, release -> no click;
//    separately, rst=0 while ARMED -> outputs 0 next cycle, later release -> no click.

Source files
------------

// File: rtl/button_panel_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : button_panel_ctl                                                |
// | Purpose  : Mouse-driven panel of N vertically stacked buttons. Reports     |
// |            hover/pressed status for highlighting and issues a one-cycle    |
// |            click pulse on press-and-release inside the same enabled        |
// |            button, followed by a hold-off window.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module button_panel_ctl #(
  parameter int N_BTN       = 3,
  parameter int X0          = 800,
  parameter int Y0          = 100,
  parameter int BTN_W       = 120,
  parameter int BTN_H       = 40,
  parameter int Y_STEP      = 60,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             left_mouse,
  input  logic [N_BTN-1:0] enable,
  output logic [N_BTN-1:0] hover,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] click
);

  localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CNT_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  localparam logic [12:0]       c_x_lo      = 13'(X0);
  localparam logic [12:0]       c_x_hi      = 13'(X0 + BTN_W);
  localparam logic [CNT_W-1:0]  c_hold_init = CNT_W'(HOLDOFF - 1);
  // Number of cycles after reset before left_s and left_p both reflect real
  // input samples; a rise seen before that is only the synchroniser refilling.
  localparam logic [WARM_W-1:0] c_warm_max  = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_left_p;
  logic [WARM_W-1:0]      r_warm;
  logic [N_BTN-1:0]       r_hit;
  logic [N_BTN-1:0]       r_hover;
  logic [N_BTN-1:0]       r_click;
  logic [1:0]             r_state;
  logic [1:0]             w_state_d;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_d;

  logic                   w_left_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_do_click;
  logic [12:0]            w_x13;
  logic [12:0]            w_y13;
  logic                   w_x_in;
  logic [N_BTN-1:0]       w_hit;
  logic [N_BTN-1:0]       w_hit_low;
  logic [N_BTN-1:0]       w_cand;
  logic [IDX_W-1:0]       w_cand_idx;
  logic [N_BTN-1:0]       w_pressed;
  logic [N_BTN-1:0]       w_click_d;

  // ---------------------------------------------------------------------------
  // Edge detection on the synchronised mouse button
  // ---------------------------------------------------------------------------
  assign w_left_s = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_left_s & ~r_left_p & (r_warm == c_warm_max);
  assign w_fall   = ~w_left_s & r_left_p;

  // ---------------------------------------------------------------------------
  // Hit test, 13-bit unsigned so X0+BTN_W etc. cannot wrap
  // ---------------------------------------------------------------------------
  assign w_x13  = {1'b0, mouse_x};
  assign w_y13  = {1'b0, mouse_y};
  assign w_x_in = (w_x13 >= c_x_lo) && (w_x13 < c_x_hi);

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_hit
      localparam logic [12:0] c_y_lo = 13'(Y0 + gi * Y_STEP);
      localparam logic [12:0] c_y_hi = 13'(Y0 + gi * Y_STEP + BTN_H);
      assign w_hit[gi] = w_x_in && (w_y13 >= c_y_lo) && (w_y13 < c_y_hi);
    end
  endgenerate

  // Keep only the lowest-index hit should buttons ever overlap
  assign w_hit_low = w_hit & (~w_hit + N_BTN'(1));
  assign w_cand    = r_hit & enable;

  // Lowest enabled button under the cursor, used when arming
  always_comb begin
    w_cand_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_cand[i]) w_cand_idx = IDX_W'(i);
    end
  end

  // Synchroniser, delayed copy, post-reset warm-up, hit and hover registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync   <= '0;
      r_left_p <= 1'b0;
      r_warm   <= '0;
      r_hit    <= '0;
      r_hover  <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], left_mouse};
      r_left_p <= w_left_s;
      if (r_warm != c_warm_max) r_warm <= r_warm + WARM_W'(1);
      r_hit    <= w_hit_low;
      r_hover  <= r_hit & enable;
    end
  end

  // FSM state register with armed index and hold-off counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // FSM next-state: arm on press over an enabled button, click on release over it
  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_cnt_d    = r_cnt;
    w_do_click = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          if (|w_cand) begin
            w_state_d = S_ARMED;
            w_idx_d   = w_cand_idx;
          end else begin
            w_state_d = S_WAIT_REL;
          end
        end
      end
      S_ARMED: begin
        // A disabled button cancels the press, even if released this cycle
        if (!enable[r_idx]) begin
          w_state_d = S_WAIT_REL;
        end else if (w_fall) begin
          if (r_hit[r_idx]) begin
            w_do_click = 1'b1;
            w_cnt_d    = c_hold_init;
            w_state_d  = S_HOLD;
          end else begin
            w_state_d  = S_IDLE;
          end
        end
      end
      S_WAIT_REL: begin
        if (!w_left_s) w_state_d = S_IDLE;
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_d = w_left_s ? S_WAIT_REL : S_IDLE;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pressed follows the cursor while armed, click decode of the armed index
  always_comb begin
    w_pressed = '0;
    w_click_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_pressed[i] = (r_state == S_ARMED) && (r_idx == IDX_W'(i)) && r_hit[i];
      w_click_d[i] = w_do_click && (r_idx == IDX_W'(i));
    end
  end

  // One-cycle registered click pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_click <= '0;
    end else begin
      r_click <= w_click_d;
    end
  end

  assign hover   = r_hover;
  assign pressed = w_pressed;
  assign click   = r_click;

endmodule
`default_nettype wire

// File: tb/tb_button_panel_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_button_panel_ctl                                             |
// | Purpose  : Self-checking bench for button_panel_ctl: directed scenarios    |
// |            plus randomized traffic against a behavioural model.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_button_panel_ctl;

  localparam int N    = 3;
  localparam int S    = 2;
  localparam int HOLD = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  mouse_x;
  logic [11:0]  mouse_y;
  logic         left_mouse;
  logic [N-1:0] enable;
  logic [N-1:0] hover;
  logic [N-1:0] pressed;
  logic [N-1:0] click;

  int checks = 0;
  int errors = 0;

  // Behavioural model: sample history, what the button currently "means"
  bit           q[$];         // q[0] = newest left_mouse sample since reset
  logic [N-1:0] m_hit;
  logic [N-1:0] m_hover;
  logic [N-1:0] m_click;
  logic [N-1:0] m_pressed;
  int           armed_btn;    // button being pressed, -1 if none
  bit           waitrel;      // press must be released before anything counts
  int           hold_left;    // cycles of hold-off remaining

  button_panel_ctl #(
    .N_BTN(N), .X0(800), .Y0(100), .BTN_W(120), .BTN_H(40),
    .Y_STEP(60), .SYNC_STAGES(S), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .left_mouse(left_mouse), .enable(enable),
    .hover(hover), .pressed(pressed), .click(click)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] hit_mask(int x, int y);
    hit_mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x >= 800 && x < 920 && y >= 100 + 60 * i && y < 140 + 60 * i) begin
        hit_mask    = '0;
        hit_mask[i] = 1'b1;
      end
    end
  endfunction

  task automatic model_edge();
    bit ls, lp, rise, fall;
    logic [N-1:0] cand, nclick;
    if (!rst) begin
      q.delete();
      m_hit = '0; m_hover = '0; m_click = '0; m_pressed = '0;
      armed_btn = -1; waitrel = 0; hold_left = 0;
      return;
    end
    ls   = (q.size() > S - 1) ? q[S-1] : 1'b0;
    lp   = (q.size() > S) ? q[S] : 1'b0;
    rise = ls && !lp && (q.size() > S);
    fall = !ls && lp;
    nclick = '0;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) waitrel = ls;
    end else if (waitrel) begin
      if (!ls) waitrel = 0;
    end else if (armed_btn >= 0) begin
      if (!enable[armed_btn]) begin
        armed_btn = -1;
        waitrel   = 1;
      end else if (fall) begin
        if (m_hit[armed_btn]) begin
          nclick[armed_btn] = 1'b1;
          hold_left = HOLD;
        end
        armed_btn = -1;
      end
    end else if (rise) begin
      cand = m_hit & enable;
      if (cand != '0) begin
        for (int i = N - 1; i >= 0; i--) if (cand[i]) armed_btn = i;
      end else begin
        waitrel = 1;
      end
    end
    m_hover = m_hit & enable;
    m_hit   = hit_mask(int'(mouse_x), int'(mouse_y));
    q.push_front(left_mouse);
    if (q.size() > S + 1) q.delete(S + 1);
    m_click   = nclick;
    m_pressed = '0;
    if (armed_btn >= 0 && m_hit[armed_btn]) m_pressed[armed_btn] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; left_mouse = 1'b0; mouse_x = 12'd850; mouse_y = 12'd110; enable = '1;
    tick_n(2);
    checks++; if (hover !== 3'b000) begin errors++; $display("FAIL reset_hover got=%b exp=000", hover); end
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL reset_pressed got=%b exp=000", pressed); end
    checks++; if (click !== 3'b000) begin errors++; $display("FAIL reset_click got=%b exp=000", click); end
    rst = 1'b1;
    tick_n(6);
  endtask

  task automatic test_click();
    logic [N-1:0] exp;
    mouse_x = 12'd850; mouse_y = 12'd170; enable = 3'b111; left_mouse = 1'b0;
    tick_n(6);
    checks++; if (hover !== 3'b010) begin errors++; $display("FAIL click_hover got=%b exp=010", hover); end
    left_mouse = 1'b1;
    tick_n(10);
    checks++; if (pressed !== 3'b010) begin errors++; $display("FAIL click_pressed got=%b exp=010", pressed); end
    checks++; if (pressed !== m_pressed) begin errors++; $display("FAIL click_pressed_model got=%b exp=%b", pressed, m_pressed); end
    left_mouse = 1'b0;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      exp = (k == S) ? 3'b010 : 3'b000;
      checks++; if (click !== exp) begin errors++; $display("FAIL click_latency k=%0d got=%b exp=%b", k, click, exp); end
    end
    tick_n(HOLD + 4);
  endtask

  task automatic test_drag_off();
    mouse_x = 12'd850; mouse_y = 12'd170; left_mouse = 1'b1;
    tick_n(8);
    checks++; if (pressed !== 3'b010) begin errors++; $display("FAIL drag_pressed got=%b exp=010", pressed); end
    mouse_y = 12'd230; tick_n(2);
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL drag_off got=%b exp=000", pressed); end
    mouse_y = 12'd170; tick_n(2);
    checks++; if (pressed !== 3'b010) begin errors++; $display("FAIL drag_back got=%b exp=010", pressed); end
    mouse_y = 12'd230; tick_n(2);
    left_mouse = 1'b0;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      checks++; if (click !== 3'b000) begin errors++; $display("FAIL drag_noclick k=%0d got=%b exp=000", k, click); end
    end
    tick_n(HOLD + 4);
  endtask

  task automatic test_outside_press();
    mouse_x = 12'd100; mouse_y = 12'd100; left_mouse = 1'b1;
    tick_n(6);
    mouse_x = 12'd850; mouse_y = 12'd110;
    tick_n(3);
    checks++; if (hover !== 3'b001) begin errors++; $display("FAIL outside_hover got=%b exp=001", hover); end
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL outside_pressed got=%b exp=000", pressed); end
    left_mouse = 1'b0;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      checks++; if (click !== 3'b000) begin errors++; $display("FAIL outside_noclick k=%0d got=%b exp=000", k, click); end
    end
    tick_n(4);
  endtask

  task automatic test_boundary();
    int           xs[7] = '{919, 920, 919, 850, 850, 800, 799};
    int           ys[7] = '{139, 139, 140, 159, 160, 100, 100};
    logic [N-1:0] ex[7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
    enable = '1; left_mouse = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mouse_x = 12'(xs[i]); mouse_y = 12'(ys[i]);
      tick_n(3);
      checks++; if (hover !== ex[i]) begin errors++; $display("FAIL boundary x=%0d y=%0d got=%b exp=%b", xs[i], ys[i], hover, ex[i]); end
    end
  endtask

  task automatic test_holdoff();
    int since;
    bit seen;
    mouse_x = 12'd850; mouse_y = 12'd110; enable = '1; left_mouse = 1'b0;
    tick_n(4);
    left_mouse = 1'b1; tick_n(6); left_mouse = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (click === 3'b001) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL holdoff_first_click got=0 exp=1"); end
    tick_n(4); since = 4;
    left_mouse = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick(); since++;
      checks++; if (click !== 3'b000 || pressed !== 3'b000) begin
        errors++; $display("FAIL holdoff_ignored t=%0d click=%b pressed=%b exp=000/000", since, click, pressed);
      end
    end
    left_mouse = 1'b0;
    while (since < 29) begin
      tick(); since++;
      checks++; if (click !== 3'b000) begin errors++; $display("FAIL holdoff_release t=%0d got=%b exp=000", since, click); end
    end
    left_mouse = 1'b1; tick_n(6); left_mouse = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (click === 3'b001) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL holdoff_second_click got=0 exp=1"); end
    tick_n(HOLD + 4);
  endtask

  task automatic test_enable_drop();
    mouse_x = 12'd850; mouse_y = 12'd170; enable = 3'b111; left_mouse = 1'b1;
    tick_n(6);
    checks++; if (pressed !== 3'b010) begin errors++; $display("FAIL endrop_armed got=%b exp=010", pressed); end
    enable = 3'b101; tick_n(3);
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL endrop_pressed got=%b exp=000", pressed); end
    checks++; if (hover !== 3'b000) begin errors++; $display("FAIL endrop_hover got=%b exp=000", hover); end
    left_mouse = 1'b0;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      checks++; if (click !== 3'b000) begin errors++; $display("FAIL endrop_noclick k=%0d got=%b exp=000", k, click); end
    end
    enable = 3'b111; tick_n(4);
  endtask

  task automatic test_reset_armed();
    mouse_x = 12'd850; mouse_y = 12'd170; left_mouse = 1'b1;
    tick_n(6);
    checks++; if (pressed !== 3'b010) begin errors++; $display("FAIL rstarm_armed got=%b exp=010", pressed); end
    rst = 1'b0; tick();
    checks++; if (hover !== 3'b000) begin errors++; $display("FAIL rstarm_hover got=%b exp=000", hover); end
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL rstarm_pressed got=%b exp=000", pressed); end
    checks++; if (click !== 3'b000) begin errors++; $display("FAIL rstarm_click got=%b exp=000", click); end
    rst = 1'b1; tick_n(6);
    checks++; if (pressed !== 3'b000) begin errors++; $display("FAIL rstarm_held got=%b exp=000", pressed); end
    checks++; if (hover !== 3'b010) begin errors++; $display("FAIL rstarm_rehover got=%b exp=010", hover); end
    left_mouse = 1'b0;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      checks++; if (click !== 3'b000) begin errors++; $display("FAIL rstarm_noclick k=%0d got=%b exp=000", k, click); end
    end
    tick_n(4);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          mouse_x = 12'($urandom); mouse_y = 12'($urandom);
        end else begin
          mouse_x = 12'($urandom_range(780, 940)); mouse_y = 12'($urandom_range(80, 280));
        end
      end
      if ($urandom_range(0, 7) == 0) left_mouse = ~left_mouse;
      if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      tick();
      checks++; if (hover !== m_hover) begin errors++; $display("FAIL rand_hover c=%0d got=%b exp=%b", c, hover, m_hover); end
      checks++; if (pressed !== m_pressed) begin errors++; $display("FAIL rand_pressed c=%0d got=%b exp=%b", c, pressed, m_pressed); end
      checks++; if (click !== m_click) begin errors++; $display("FAIL rand_click c=%0d got=%b exp=%b", c, click, m_click); end
    end
    rst = 1'b1; enable = '1; left_mouse = 1'b0;
    tick_n(HOLD + 4);
  endtask

  initial begin
    rst = 1'b0; left_mouse = 1'b0; mouse_x = '0; mouse_y = '0; enable = '0;
    armed_btn = -1; waitrel = 0; hold_left = 0;
    m_hit = '0; m_hover = '0; m_click = '0; m_pressed = '0;
    test_reset();
    test_click();
    test_drag_off();
    test_outside_press();
    test_boundary();
    test_holdoff();
    test_enable_drop();
    test_reset_armed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
